bit_serializer: RTL
===================

// Module: bit_serializer
//
// PURPOSE
//   Upstream feeder for the serial detector stage. Accepts parallel words over a valid/ready
//   handshake and shifts them out one bit per clk on ser_out, which drives the detector's
//   1-bit input 'a'. A one-word holding register lets consecutive words stream gap-free.
//   Deterministic, replayable stimulus in place of per-cycle random bits.
//
// PARAMETERS
//   WIDTH      8   bits per word, >=2
//   MSB_FIRST  1   1: bit WIDTH-1 shifted first; 0: bit 0 shifted first
//
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-low reset
//   in_data      in   WIDTH  parallel word
//   in_valid     in   1      in_data valid
//   in_ready     out  1      block can take a word this cycle
//   ser_out      out  1      serial bit to detector input 'a'
//   ser_valid    out  1      ser_out carries a frame bit this cycle
//   frame_start  out  1      high with the first bit of each frame
//   busy         out  1      shifter or holding register occupied
//
// BEHAVIOUR
//   - rst low (async): state=IDLE, shifter=0, bit_cnt=0, hold_full=0; ser_out=0, ser_valid=0,
//     frame_start=0, busy=0. in_ready=1 as soon as rst deasserts.
//   - in_ready = !hold_full (combinational). Transfer = in_valid & in_ready at a rising edge.
//   - FRAME_LEN = WIDTH (+1 with SER_PARITY_EN). bit_cnt width = clog2(FRAME_LEN+1).
//   - IDLE: transfer loads the word into the shifter (hold stays empty), -> SHIFT,
//     bit_cnt=0. Latency: first bit on ser_out the cycle after the transfer, frame_start=1.
//   - SHIFT: ser_out/ser_valid/frame_start are registered. ser_valid=1 for exactly FRAME_LEN
//     cycles per word. frame_start=1 only when bit_cnt==0. bit_cnt increments each cycle.
//     A transfer during SHIFT writes the holding register, hold_full=1.
//   - Last bit (bit_cnt==FRAME_LEN-1):
//       hold_full -> load hold into shifter, hold_full=0, bit_cnt=0, frame_start=1 next cycle
//         (zero-gap back-to-back).
//       hold empty, transfer this cycle -> load in_data directly into the shifter. Zero gap.
//       hold empty, no transfer -> IDLE next cycle. ser_out=0, ser_valid=0.
//   - Transfer into an empty hold on the last-bit cycle bypasses the hold. No word is ever
//     dropped or duplicated.
//   - busy = (state==SHIFT) | hold_full.
//   - rst asserted mid-frame: frame and any held word are discarded at once. Outputs return
//     to reset values with no trailing bits.
//   - ser_out is 0 whenever ser_valid=0.
//
// CONFIGURATION
//   SER_PARITY_EN defined: one extra bit after the WIDTH data bits, even parity (XOR of the
//     word), ser_valid=1 during it. FRAME_LEN=WIDTH+1.
//   undefined: no parity bit, FRAME_LEN=WIDTH, no parity logic synthesized.
//
// TESTING
//   1 Reset: hold rst=0 15ns, release -> ser_out=0, ser_valid=0, busy=0, in_ready=1.
//   2 Single word 8'hB4, MSB_FIRST=1, pulse in_valid 1 cycle -> ser_out 1,0,1,1,0,1,0,0 on the
//     next 8 cycles. frame_start only on first. Then ser_valid=0, busy=0.
//   3 Back-to-back 8'hA5 then 8'h3C with in_valid held -> 16 contiguous ser_valid cycles,
//     frame_start on cycles 1 and 9. in_ready low while hold full.
//   4 MSB_FIRST=0, word 8'h01 -> first serial bit 1, next seven 0.
//   5 Reset mid-frame: rst=0 after bit 3 of 8'hFF, with a word held -> outputs 0 at once.
//     After release, no residual bits and in_ready=1.
//   6 SER_PARITY_EN: 8'h07 -> 9 valid bits, final bit 1. 8'h03 -> final bit 0.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with a one-word holding register for gap-free streaming.
// Define SER_PARITY_EN to append an even-parity bit after the data bits of each frame.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_frame_start;
`ifdef SER_PARITY_EN
    logic             r_parity;
`endif

    logic             w_xfer;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_next_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign in_ready    = ~r_hold_full;
    assign w_xfer      = in_valid & in_ready;
    assign w_last      = (r_bit_cnt == LAST);
    assign w_next_word = r_hold_full ? r_hold : in_data;
    // A new frame starts from idle, or on the last bit when a word is held or arriving.
    assign w_load      = ((r_state == S_IDLE) & w_xfer) |
                         ((r_state == S_SHIFT) & w_last & (r_hold_full | w_xfer));

    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign busy        = (r_state == S_SHIFT) | r_hold_full;

    // r_shift holds the bits still to be sent after the one currently on ser_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_bit_cnt     <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity      <= 1'b0;
`endif
        end else if (w_load) begin
            r_state       <= S_SHIFT;
            r_shift       <= advance(w_next_word);
            r_ser_out     <= first_bit(w_next_word);
            r_ser_valid   <= 1'b1;
            r_frame_start <= 1'b1;
            r_bit_cnt     <= '0;
            r_hold_full   <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity      <= ^w_next_word;
`endif
        end else if (r_state == S_SHIFT) begin
            if (w_last) begin
                r_state       <= S_IDLE;
                r_ser_out     <= 1'b0;
                r_ser_valid   <= 1'b0;
                r_frame_start <= 1'b0;
                r_bit_cnt     <= '0;
            end else begin
                r_bit_cnt     <= r_bit_cnt + CW'(1);
                r_frame_start <= 1'b0;
                r_shift       <= advance(r_shift);
`ifdef SER_PARITY_EN
                r_ser_out     <= (r_bit_cnt == DATA_LAST) ? r_parity : first_bit(r_shift);
`else
                r_ser_out     <= first_bit(r_shift);
`endif
                if (w_xfer) begin
                    r_hold      <= in_data;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end

endmodule
